// File: rtl/hazard_fwd_unit_pkg.sv
// hazard_fwd_unit_pkg: stall bus layout, stall patterns and FSM state encodings
package hazard_fwd_unit_pkg;
    localparam int STALL_BUS = 6;
    localparam int S_PC    = 0;
    localparam int S_IFID  = 1;
    localparam int S_IDEX  = 2;
    localparam int S_EXMEM = 3;
    localparam int S_MEMWB = 4;
    localparam int S_WB    = 5;
    localparam logic [STALL_BUS-1:0] STALL_MEMW = 6'b011111;
    localparam logic [STALL_BUS-1:0] STALL_EXT  = 6'b001111;
    localparam logic [STALL_BUS-1:0] STALL_LU   = 6'b000111;
    localparam logic [STALL_BUS-1:0] STALL_NONE = 6'b000000;
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        LU   = 2'd1,
        EXT  = 2'd2,
        MEMW = 2'd3
    } stall_st_e;
endpackage

// File: rtl/hazard_fwd_unit_fwd_match.sv
// hazard_fwd_unit_fwd_match: youngest-first producer match for one register read port
module hazard_fwd_unit_fwd_match #(
    parameter int NUM_STG = 3,
    parameter int REG_AW  = 5,
    parameter int DW      = 32
) (
    input  logic [REG_AW-1:0]         addr,
    input  logic                      used,
    input  logic [NUM_STG-1:0]        stg_we,
    input  logic [NUM_STG*REG_AW-1:0] stg_waddr,
    input  logic [NUM_STG*DW-1:0]     stg_wdata,
    input  logic [NUM_STG-1:0]        stg_wrdy,
    output logic                      hit,
    output logic                      rdy,
    output logic [DW-1:0]             data
);
    // walk oldest to youngest so the youngest matching stage overwrites the result
    always_comb begin
        hit  = 1'b0;
        rdy  = 1'b0;
        data = '0;
        for (int s = NUM_STG - 1; s >= 0; s--) begin
            if (used && addr != '0 && stg_we[s] && stg_waddr[s*REG_AW +: REG_AW] == addr) begin
                hit  = 1'b1;
                rdy  = stg_wrdy[s];
                data = stg_wdata[s*DW +: DW];
            end
        end
    end
endmodule

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: RAW forwarding into EX plus core-wide stall generation and stall-cycle counter
module hazard_fwd_unit
    import hazard_fwd_unit_pkg::*;
#(
    parameter int NUM_RD  = 2,
    parameter int NUM_STG = 3,
    parameter int REG_AW  = 5,
    parameter int DW      = 32,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic [NUM_RD*REG_AW-1:0]  rd_addr,
    input  logic [NUM_RD-1:0]         rd_used,
    input  logic [NUM_STG-1:0]        stg_we,
    input  logic [NUM_STG*REG_AW-1:0] stg_waddr,
    input  logic [NUM_STG*DW-1:0]     stg_wdata,
    input  logic [NUM_STG-1:0]        stg_wrdy,
    input  logic                      ext_busy,
    input  logic                      mem_wait,
    output logic [NUM_RD-1:0]         fwd_sel,
    output logic [NUM_RD*DW-1:0]      fwd_data,
    output logic [STALL_BUS-1:0]      stall,
    output logic [1:0]                stall_st,
    output logic [CNT_W-1:0]          stall_cnt
);
    logic [NUM_RD-1:0]    hit, rdy;
    logic [NUM_RD*DW-1:0] mdata, cap_data;
    logic                 lu_req, bubble, hold;
    logic [NUM_RD-1:0]    fwd_sel_d, fwd_sel_q;
    logic [NUM_RD*DW-1:0] fwd_data_d, fwd_data_q;
    stall_st_e            st_d, st_q;
    logic [CNT_W-1:0]     cnt_d, cnt_q;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_match
        hazard_fwd_unit_fwd_match #(.NUM_STG(NUM_STG), .REG_AW(REG_AW), .DW(DW)) u_match (
            .addr      (rd_addr[p*REG_AW +: REG_AW]),
            .used      (rd_used[p]),
            .stg_we    (stg_we),
            .stg_waddr (stg_waddr),
            .stg_wdata (stg_wdata),
            .stg_wrdy  (stg_wrdy),
            .hit       (hit[p]),
            .rdy       (rdy[p]),
            .data      (mdata[p*DW +: DW])
        );
    end

    always_comb begin
        lu_req = id_valid && !flush && |(hit & ~rdy);
        stall  = !rst ? STALL_NONE : mem_wait ? STALL_MEMW : ext_busy ? STALL_EXT :
                 lu_req ? STALL_LU : STALL_NONE;
        st_d   = mem_wait ? MEMW : ext_busy ? EXT : lu_req ? LU : RUN;
        bubble = flush || (stall[S_IDEX] && !stall[S_EXMEM]);
        hold   = stall[S_EXMEM];
        for (int p = 0; p < NUM_RD; p++)
            cap_data[p*DW +: DW] = (hit[p] && rdy[p]) ? mdata[p*DW +: DW] : '0;
        // values are captured, not addresses, so a held EX operand survives MEM/WB retiring
        fwd_sel_d  = bubble ? '0 : hold ? fwd_sel_q : hit & rdy;
        fwd_data_d = bubble ? '0 : hold ? fwd_data_q : cap_data;
        cnt_d      = (st_d != RUN && cnt_q != {CNT_W{1'b1}}) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_sel_q  <= '0;
            fwd_data_q <= '0;
            st_q       <= RUN;
            cnt_q      <= '0;
        end else begin
            fwd_sel_q  <= fwd_sel_d;
            fwd_data_q <= fwd_data_d;
            st_q       <= st_d;
            cnt_q      <= cnt_d;
        end
    end

    assign fwd_sel   = fwd_sel_q;
    assign fwd_data  = fwd_data_q;
    assign stall_st  = st_q;
    assign stall_cnt = cnt_q;
endmodule
